cpu_ctrl_fsm_v2: RTL and testbench
==================================

Name: cpu_ctrl_fsm_v2

Overview:
Second-generation multicycle control unit for the 16-bit soft CPU. It sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the same datapath selects and enables as the current controller. It adds a ready/request memory handshake with a parametrised timeout, full 16-way condition evaluation for branches and jumps, and a sticky FAULT state. It sits between the instruction register, PSR and memory port, and the PC, register file and ALU muxes.

Parameters:
INSTR_W, 16, instruction width; opcode = [INSTR_W-1:INSTR_W-4], cond/rdst = [11:8], ext = [7:4]; must be >= 16.
FLAG_W, 5, PSR width; bit map C=[0], L=[1], F=[2], Z=[3], N=[4].
MEM_TIMEOUT, 15, max cycles to wait for memReady before FAULT; 0 disables the timeout.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
instruction  in  INSTR_W  current IR contents.
psrFlags  in  FLAG_W  current PSR flags.
memReady  in  1  memory completes the current request this cycle.
memReq  out  1  memory request (fetch, load or store).
pcEn, pcIncOrSet, irEn, rfWe, pcRegSel, r2ImSel, brWe, wbRegAlu, psrEn  out  1 each  datapath controls; meanings as in the current controller.
immTypeSel  out  2  immediate type: 00 raw, 01 sign-extended, 10 zero-extended, 11 jump.
busError  out  1  sticky; high in FAULT.
stateOut  out  3  current state encoding, for debug.

Behaviour:
- State encoding: FETCH=000, DECODE=001, EXECUTE=010, MEM=011, WRITEBACK=100, FAULT=101. Codes 110/111 go to FETCH on the next edge.
- Reset: while reset=0, state=FETCH, wait counter=0, all enables/memReq/busError=0, pcRegSel=1, wbRegAlu=1, immTypeSel=00. Reset has priority in every state, including mid-wait and FAULT.
- All outputs are combinational from state, instruction and psrFlags.
- FETCH: memReq=1. If memReady=1, go to DECODE; otherwise stay.
- DECODE: irEn=1 for exactly one cycle, then go to EXECUTE.
- EXECUTE: drive selects. LOAD (op 0100 ext 0000) and STORE (op 0100 ext 0100) go to MEM; everything else goes to WRITEBACK.
- MEM: memReq=1, selects held.
  - STORE: brWe=1 only in the cycle memReady=1.
  - On memReady=1: STORE goes to FETCH with pcEn=1, pcIncOrSet=0 in that same cycle; LOAD goes to WRITEBACK.
- WRITEBACK: pcEn=1 and rfWe=1 by default, selects held, then go to FETCH.
- Selects (valid in EXECUTE, MEM and WRITEBACK):
  - R-type 0000: pcRegSel=1, r2ImSel=0.
  - ANDI 0001 / ORI 0010 / XORI 0011 / MOVI 1101: r2ImSel=1, imm=10.
  - ADDI 0101 / SUBI 1001 / CMPI 1011: r2ImSel=1, imm=01.
  - LSHI 1000 / LUI 1111: r2ImSel=1, imm=00.
  - Bcond 1100: pcRegSel=0, r2ImSel=1, imm=01.
  - JCOND (0100 ext 1100): r2ImSel=0, imm=11.
  - JAL (0100 ext 1111): pcRegSel=0, r2ImSel=1, imm=11.
- WRITEBACK specifics:
  - LOAD: wbRegAlu=0.
  - CMP (0000 ext 1011) / CMPI: psrEn=1, rfWe=0. psrEn is never asserted in EXECUTE.
  - Bcond / JCOND: rfWe=0, pcIncOrSet=cond(instruction[11:8]).
  - JAL: rfWe=1 (link), pcIncOrSet=1.
  - Undefined opcode or ext: rfWe=0, pcIncOrSet=0 (NOP, PC+1).
- cond(): 0 Z; 1 !Z; 2 C; 3 !C; 4 L; 5 !L; 6 N; 7 !N; 8 F; 9 !F; 10 !Z&!L; 11 Z|L; 12 !N&!Z; 13 N|Z; 14 always 1; 15 always 0.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each FETCH/MEM cycle with memReady=0.
  - If MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT with memReady=0, go to FAULT.
  - memReady=1 in the same cycle wins over timeout.
- FAULT: busError=1, all enables and memReq=0; leave only by reset.

Test Plan:
- ADDI r3,#-2 (0x5_3_FE), memReady tied 1 -> stateOut 000,001,010,100,000; irEn high 1 cycle; rfWe=1, pcEn=1, immTypeSel=01 in WRITEBACK; total 4 cycles.
- Bcond EQ (0xC0xx), psrFlags Z=1 then Z=0 -> pcIncOrSet=1 then 0 in WRITEBACK; rfWe=0; cond 15 never taken; cond 14 always taken.
- LOAD with memReady low for 3 MEM cycles -> memReq held 3+1 cycles; WRITEBACK wbRegAlu=0, rfWe=1. STORE -> brWe high in exactly the ready cycle; no rfWe.
- memReady held 0 in FETCH, MEM_TIMEOUT=15 -> FAULT after 16 FETCH cycles, busError=1; memReady=1 on cycle 16 instead -> DECODE, no fault.
- CMP r1,r2 (0x0_1_B_2) -> psrEn high exactly 1 cycle (WRITEBACK), rfWe=0.
- reset pulsed low mid-MEM wait and in FAULT -> immediately stateOut=000, busError=0, memReq=0; normal fetch resumes after release.

Source files
------------

// File: rtl/cpu_ctrl_fsm_v2_if.sv
// Controller <-> datapath/memory bundle for the 16-bit multicycle CPU.
// master = controller, slave = datapath and memory port.
interface cpu_ctrl_fsm_v2_if #(
  parameter int INSTR_W = 16,
  parameter int FLAG_W  = 5
);
  logic [INSTR_W-1:0] instruction;
  logic [FLAG_W-1:0]  psrFlags;
  logic               memReady;
  logic               memReq;
  logic               pcEn;
  logic               pcIncOrSet;
  logic               irEn;
  logic               rfWe;
  logic               pcRegSel;
  logic               r2ImSel;
  logic               brWe;
  logic               wbRegAlu;
  logic               psrEn;
  logic [1:0]         immTypeSel;
  logic               busError;
  logic [2:0]         stateOut;

  modport master (
    input  instruction, psrFlags, memReady,
    output memReq, pcEn, pcIncOrSet, irEn,
    output rfWe, pcRegSel, r2ImSel, brWe,
    output wbRegAlu, psrEn, immTypeSel,
    output busError, stateOut
  );

  modport slave (
    output instruction, psrFlags, memReady,
    input  memReq, pcEn, pcIncOrSet, irEn,
    input  rfWe, pcRegSel, r2ImSel, brWe,
    input  wbRegAlu, psrEn, immTypeSel,
    input  busError, stateOut
  );
endinterface

// File: rtl/cpu_ctrl_fsm_v2.sv
// Multicycle control FSM: fetch/decode/execute/mem/writeback with
// memory ready handshake, wait timeout and sticky bus fault.
module cpu_ctrl_fsm_v2 #(
  parameter int INSTR_W     = 16,
  parameter int FLAG_W      = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input logic clock,
  input logic reset,
  cpu_ctrl_fsm_v2_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH = 3'b000,
    S_DEC   = 3'b001,
    S_EXE   = 3'b010,
    S_MEM   = 3'b011,
    S_WB    = 3'b100,
    S_FAULT = 3'b101
  } state_t;

  localparam int CNT_W = (MEM_TIMEOUT > 0) ?
    $clog2(MEM_TIMEOUT + 1) + 1 : 1;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_tmo;
  logic             w_wait;

  logic [3:0] w_op;
  logic [3:0] w_cnd;
  logic [3:0] w_ext;
  logic       w_rtype, w_logi, w_arii, w_shi;
  logic       w_bcc, w_jcc, w_jal, w_ld, w_st;
  logic       w_cmp, w_undef, w_taken;
  logic       w_pcRegSel, w_r2ImSel;
  logic [1:0] w_imm;
  logic       w_unused;

  assign w_op  = bus.instruction[INSTR_W-1 -: 4];
  assign w_cnd = bus.instruction[11:8];
  assign w_ext = bus.instruction[7:4];
  assign w_unused = ^{bus.instruction, bus.psrFlags};

  assign w_rtype = (w_op == 4'b0000);
  assign w_logi  = (w_op == 4'b0001) || (w_op == 4'b0010) ||
                   (w_op == 4'b0011) || (w_op == 4'b1101);
  assign w_arii  = (w_op == 4'b0101) || (w_op == 4'b1001) ||
                   (w_op == 4'b1011);
  assign w_shi   = (w_op == 4'b1000) || (w_op == 4'b1111);
  assign w_bcc   = (w_op == 4'b1100);
  assign w_jcc   = (w_op == 4'b0100) && (w_ext == 4'b1100);
  assign w_jal   = (w_op == 4'b0100) && (w_ext == 4'b1111);
  assign w_ld    = (w_op == 4'b0100) && (w_ext == 4'b0000);
  assign w_st    = (w_op == 4'b0100) && (w_ext == 4'b0100);
  assign w_cmp   = (w_rtype && (w_ext == 4'b1011)) ||
                   (w_op == 4'b1011);
  assign w_undef = !(w_rtype || w_logi || w_arii || w_shi ||
                     w_bcc || w_jcc || w_jal || w_ld || w_st);

  // flags: C=0 L=1 F=2 Z=3 N=4
  always_comb begin
    w_taken = 1'b0;
    unique case (w_cnd)
      4'd0:  w_taken =  bus.psrFlags[3];
      4'd1:  w_taken = !bus.psrFlags[3];
      4'd2:  w_taken =  bus.psrFlags[0];
      4'd3:  w_taken = !bus.psrFlags[0];
      4'd4:  w_taken =  bus.psrFlags[1];
      4'd5:  w_taken = !bus.psrFlags[1];
      4'd6:  w_taken =  bus.psrFlags[4];
      4'd7:  w_taken = !bus.psrFlags[4];
      4'd8:  w_taken =  bus.psrFlags[2];
      4'd9:  w_taken = !bus.psrFlags[2];
      4'd10: w_taken = !bus.psrFlags[3] &&
                       !bus.psrFlags[1];
      4'd11: w_taken =  bus.psrFlags[3] ||
                        bus.psrFlags[1];
      4'd12: w_taken = !bus.psrFlags[4] &&
                       !bus.psrFlags[3];
      4'd13: w_taken =  bus.psrFlags[4] ||
                        bus.psrFlags[3];
      4'd14: w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_pcRegSel = 1'b1;
    w_r2ImSel  = 1'b0;
    w_imm      = 2'b00;
    unique case (1'b1)
      w_logi: begin
        w_r2ImSel = 1'b1;
        w_imm     = 2'b10;
      end
      w_arii: begin
        w_r2ImSel = 1'b1;
        w_imm     = 2'b01;
      end
      w_shi: begin
        w_r2ImSel = 1'b1;
      end
      w_bcc: begin
        w_pcRegSel = 1'b0;
        w_r2ImSel  = 1'b1;
        w_imm      = 2'b01;
      end
      w_jcc: begin
        w_imm = 2'b11;
      end
      w_jal: begin
        w_pcRegSel = 1'b0;
        w_r2ImSel  = 1'b1;
        w_imm      = 2'b11;
      end
      default: ;
    endcase
  end

  // counter only runs while stalled on memory; any exit clears it
  assign w_wait = ((r_state == S_FETCH) || (r_state == S_MEM)) &&
                  !bus.memReady;
  assign w_cnt_nxt = w_wait ? r_cnt + CNT_W'(1) : '0;
  assign w_tmo = (MEM_TIMEOUT != 0) &&
                 (r_cnt == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    unique case (r_state)
      S_FETCH: begin
        if (bus.memReady) w_next = S_DEC;
        else if (w_tmo)   w_next = S_FAULT;
        else              w_next = S_FETCH;
      end
      S_DEC: w_next = S_EXE;
      S_EXE: w_next = (w_ld || w_st) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.memReady) w_next = w_st ? S_FETCH : S_WB;
        else if (w_tmo)   w_next = S_FAULT;
        else              w_next = S_MEM;
      end
      S_WB:    w_next = S_FETCH;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    bus.memReq     = 1'b0;
    bus.pcEn       = 1'b0;
    bus.pcIncOrSet = 1'b0;
    bus.irEn       = 1'b0;
    bus.rfWe       = 1'b0;
    bus.pcRegSel   = 1'b1;
    bus.r2ImSel    = 1'b0;
    bus.brWe       = 1'b0;
    bus.wbRegAlu   = 1'b1;
    bus.psrEn      = 1'b0;
    bus.immTypeSel = 2'b00;
    bus.busError   = 1'b0;
    bus.stateOut   = r_state;
    if (reset) begin
      unique case (r_state)
        S_FETCH: bus.memReq = 1'b1;
        S_DEC:   bus.irEn   = 1'b1;
        S_EXE: begin
          bus.pcRegSel   = w_pcRegSel;
          bus.r2ImSel    = w_r2ImSel;
          bus.immTypeSel = w_imm;
        end
        S_MEM: begin
          bus.memReq     = 1'b1;
          bus.pcRegSel   = w_pcRegSel;
          bus.r2ImSel    = w_r2ImSel;
          bus.immTypeSel = w_imm;
          if (w_st && bus.memReady) begin
            bus.brWe = 1'b1;
            bus.pcEn = 1'b1;
          end
        end
        S_WB: begin
          bus.pcEn       = 1'b1;
          bus.rfWe       = 1'b1;
          bus.pcRegSel   = w_pcRegSel;
          bus.r2ImSel    = w_r2ImSel;
          bus.immTypeSel = w_imm;
          unique case (1'b1)
            w_ld: bus.wbRegAlu = 1'b0;
            w_cmp: begin
              bus.psrEn = 1'b1;
              bus.rfWe  = 1'b0;
            end
            (w_bcc || w_jcc): begin
              bus.rfWe       = 1'b0;
              bus.pcIncOrSet = w_taken;
            end
            w_jal:   bus.pcIncOrSet = 1'b1;
            w_undef: bus.rfWe       = 1'b0;
            default: ;
          endcase
        end
        S_FAULT: bus.busError = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm_v2.sv
// Directed scoreboard bench for cpu_ctrl_fsm_v2: the driver queues the
// expected per-cycle outputs, a negedge monitor pops and compares.
module tb_cpu_ctrl_fsm_v2;

  logic clk;
  logic rst_n;

  cpu_ctrl_fsm_v2_if #(.INSTR_W(16), .FLAG_W(5)) ifc ();

  cpu_ctrl_fsm_v2 #(
    .INSTR_W(16), .FLAG_W(5), .MEM_TIMEOUT(15)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus(ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // en : memReq pcEn pcIncOrSet irEn rfWe brWe psrEn busError
  // sel: pcRegSel r2ImSel wbRegAlu imm[1:0]
  localparam logic [7:0] EF  = 8'b1000_0000;
  localparam logic [7:0] ED  = 8'b0001_0000;
  localparam logic [4:0] SD  = 5'b10100;

  logic [15:0] act;
  assign act = {ifc.stateOut,
                ifc.memReq, ifc.pcEn, ifc.pcIncOrSet, ifc.irEn,
                ifc.rfWe, ifc.brWe, ifc.psrEn, ifc.busError,
                ifc.pcRegSel, ifc.r2ImSel, ifc.wbRegAlu,
                ifc.immTypeSel};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (act !== e.v) begin
        n_err++;
        $display("FAIL %s: got %b_%b_%b want %b_%b_%b", e.tag,
                 act[15:13], act[12:5], act[4:0],
                 e.v[15:13], e.v[12:5], e.v[4:0]);
      end
    end
  end

  task automatic cyc(input logic rst, input logic rdy,
                     input logic [15:0] ins, input logic [4:0] fl,
                     input logic [2:0] st, input logic [7:0] en,
                     input logic [4:0] sel, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = rst;
    ifc.memReady    = rdy;
    ifc.instruction = ins;
    ifc.psrFlags    = fl;
    e.tag = tag;
    e.v   = {st, en, sel};
    q.push_back(e);
  endtask

  task automatic run_alu(input logic [15:0] ins, input logic [4:0] fl,
                         input logic [4:0] exs, input logic [7:0] wbe,
                         input logic [4:0] wbs, input string tag);
    cyc(1, 1, ins, fl, 3'd0, EF, SD, {tag, "_f"});
    cyc(1, 1, ins, fl, 3'd1, ED, SD, {tag, "_d"});
    cyc(1, 1, ins, fl, 3'd2, 8'h00, exs, {tag, "_ex"});
    cyc(1, 1, ins, fl, 3'd4, wbe, wbs, {tag, "_wb"});
  endtask

  task automatic ldst_front(input logic [15:0] ins, input string tag);
    cyc(1, 1, ins, 5'd0, 3'd0, EF, SD, {tag, "_f"});
    cyc(1, 1, ins, 5'd0, 3'd1, ED, SD, {tag, "_d"});
    cyc(1, 1, ins, 5'd0, 3'd2, 8'h00, SD, {tag, "_ex"});
  endtask

  initial begin
    rst_n           = 1'b0;
    ifc.memReady    = 1'b0;
    ifc.instruction = '0;
    ifc.psrFlags    = '0;

    cyc(0, 1, 16'h53FE, 5'd0, 3'd0, 8'h00, SD, "reset");

    run_alu(16'h53FE, 5'b00000, 5'b11101, 8'b0100_1000,
            5'b11101, "addi");
    run_alu(16'hC005, 5'b01000, 5'b01101, 8'b0110_0000,
            5'b01101, "beq_z1");
    run_alu(16'hC005, 5'b00000, 5'b01101, 8'b0100_0000,
            5'b01101, "beq_z0");
    run_alu(16'hCF00, 5'b11111, 5'b01101, 8'b0100_0000,
            5'b01101, "bc15");
    run_alu(16'hCE00, 5'b00000, 5'b01101, 8'b0110_0000,
            5'b01101, "bc14");
    run_alu(16'hCB00, 5'b00010, 5'b01101, 8'b0110_0000,
            5'b01101, "bc11_l");
    run_alu(16'hCC00, 5'b10000, 5'b01101, 8'b0100_0000,
            5'b01101, "bc12_n");
    run_alu(16'h42C0, 5'b00001, 5'b10111, 8'b0110_0000,
            5'b10111, "jcs");
    run_alu(16'h45F0, 5'b00000, 5'b01111, 8'b0110_1000,
            5'b01111, "jal");
    run_alu(16'h01B2, 5'b00000, SD, 8'b0100_0010, SD, "cmp");
    run_alu(16'hB105, 5'b00000, 5'b11101, 8'b0100_0010,
            5'b11101, "cmpi");
    run_alu(16'h2107, 5'b00000, 5'b11110, 8'b0100_1000,
            5'b11110, "ori");
    run_alu(16'hF1AB, 5'b00000, 5'b11100, 8'b0100_1000,
            5'b11100, "lui");
    run_alu(16'h7000, 5'b00000, SD, 8'b0100_0000, SD, "undef");

    ldst_front(16'h4300, "load");
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 16'h4300, 5'd0, 3'd3, EF, SD, "load_mwait");
    cyc(1, 1, 16'h4300, 5'd0, 3'd3, EF, SD, "load_mrdy");
    cyc(1, 1, 16'h4300, 5'd0, 3'd4, 8'b0100_1000, 5'b10000,
        "load_wb");

    ldst_front(16'h4340, "store");
    cyc(1, 0, 16'h4340, 5'd0, 3'd3, EF, SD, "store_mwait");
    cyc(1, 1, 16'h4340, 5'd0, 3'd3, 8'b1100_0100, SD,
        "store_mrdy");
    cyc(1, 1, 16'h4340, 5'd0, 3'd0, EF, SD, "store_ret");
    cyc(1, 1, 16'h4340, 5'd0, 3'd1, ED, SD, "store_ret_d");
    cyc(1, 1, 16'h4340, 5'd0, 3'd2, 8'h00, SD, "store_ret_ex");
    cyc(1, 1, 16'h4340, 5'd0, 3'd3, 8'b1100_0100, SD,
        "store_ret_m");

    for (int i = 0; i < 15; i++)
      cyc(1, 0, 16'h53FE, 5'd0, 3'd0, EF, SD, "nearto_f");
    run_alu(16'h53FE, 5'b00000, 5'b11101, 8'b0100_1000,
            5'b11101, "nearto");

    for (int i = 0; i < 16; i++)
      cyc(1, 0, 16'h53FE, 5'd0, 3'd0, EF, SD, "to_f");
    cyc(1, 0, 16'h53FE, 5'd0, 3'd5, 8'b0000_0001, SD, "fault");
    cyc(1, 1, 16'h53FE, 5'd0, 3'd5, 8'b0000_0001, SD,
        "fault_sticky");
    cyc(0, 1, 16'h53FE, 5'd0, 3'd0, 8'h00, SD, "fault_rst");
    run_alu(16'h53FE, 5'b00000, 5'b11101, 8'b0100_1000,
            5'b11101, "post_fault");

    ldst_front(16'h4300, "ld2");
    cyc(1, 0, 16'h4300, 5'd0, 3'd3, EF, SD, "ld2_mwait");
    cyc(1, 0, 16'h4300, 5'd0, 3'd3, EF, SD, "ld2_mwait");
    cyc(0, 0, 16'h4300, 5'd0, 3'd0, 8'h00, SD, "mem_rst");
    cyc(1, 0, 16'h53FE, 5'd0, 3'd0, EF, SD, "mem_rst_f");
    run_alu(16'h53FE, 5'b00000, 5'b11101, 8'b0100_1000,
            5'b11101, "post_mem_rst");

    @(posedge clk);
    repeat (2) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
